// File: rtl/data_cache_arbiter.sv
// Round-robin arbiter sharing the single data-cache BRAM port among NUM_REQ requesters.
// Supports bounded lock bursts and routes read data back to the requester that issued the read.
module data_cache_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_DEPTH   = 4096,
  parameter int READ_LATENCY = 2,
  parameter int MAX_LOCK     = 4,
  localparam int ADDR_W      = $clog2(DATA_DEPTH)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic [NUM_REQ-1:0]            req_we_in,
  input  logic [NUM_REQ-1:0]            req_lock_in,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_in,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  output logic [DATA_WIDTH-1:0]         rsp_data_out,
  output logic                          bram_en_out,
  output logic                          bram_we_out,
  output logic [ADDR_W-1:0]             bram_addr_out,
  output logic [DATA_WIDTH-1:0]         bram_din_out,
  input  logic [DATA_WIDTH-1:0]         bram_dout_in
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1'b1);

  logic [ID_W-1:0]         ptr_r;
  logic [CNT_W-1:0]        lock_cnt_r;
  logic [ID_W-1:0]         cand_s;
  logic                    take_s;
  logic                    grant_vld_s;
  logic                    grant_ok_s;
  logic [ID_W-1:0]         grant_id_s;
  logic [CNT_W-1:0]        eff_cnt_s;
  logic                    keep_s;
  logic [READ_LATENCY-1:0] pipe_vld_r;
  logic [ID_W-1:0]         pipe_id_r [READ_LATENCY];
  logic [NUM_REQ-1:0]      rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_data_r;

  // Modular increment of a requester index without relying on power-of-two wrap.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NUM_REQ)) begin
      sum = sum - 32'(NUM_REQ);
    end else begin
      sum = sum;
    end
    return sum[ID_W-1:0];
  endfunction

  // Search requesters starting at ptr; first valid one wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = '0;
    cand_s      = '0;
    take_s      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s      = wrap_add(ptr_r, unsigned'(k));
      take_s      = ~grant_vld_s & req_valid_in[cand_s];
      grant_id_s  = take_s ? cand_s : grant_id_s;
      grant_vld_s = grant_vld_s | take_s;
    end
  end

  // Grant and BRAM port mux; reset forces the port idle even with requests pending.
  always_comb begin
    grant_ok_s    = grant_vld_s & rst_in;
    req_ready_out = grant_ok_s ? (ONE_HOT_0 << grant_id_s) : '0;
    bram_en_out   = grant_ok_s;
    bram_we_out   = grant_ok_s & req_we_in[grant_id_s];
    bram_addr_out = req_addr_in[grant_id_s*ADDR_W +: ADDR_W];
    bram_din_out  = req_wdata_in[grant_id_s*DATA_WIDTH +: DATA_WIDTH];
    // A running lock count only belongs to the requester currently holding ptr.
    eff_cnt_s     = (grant_id_s == ptr_r) ? lock_cnt_r : '0;
    keep_s        = req_lock_in[grant_id_s] & ((32'(eff_cnt_s) + 32'd1) < 32'(MAX_LOCK));
  end

  // Priority pointer and lock burst counter.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ptr_r      <= '0;
      lock_cnt_r <= '0;
    end else if (grant_ok_s) begin
      if (keep_s) begin
        ptr_r      <= grant_id_s;
        lock_cnt_r <= eff_cnt_s + CNT_W'(1'b1);
      end else begin
        ptr_r      <= wrap_add(grant_id_s, 32'd1);
        lock_cnt_r <= '0;
      end
    end else begin
      ptr_r      <= ptr_r;
      lock_cnt_r <= lock_cnt_r;
    end
  end

  // Read tag pipeline aligned with the BRAM read latency.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pipe_vld_r <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_id_r[i] <= '0;
      end
    end else begin
      pipe_vld_r[0] <= grant_ok_s & ~bram_we_out;
      pipe_id_r[0]  <= grant_id_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_id_r[i]  <= pipe_id_r[i-1];
      end
    end
  end

  // Registered response strobe; data holds between responses.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
    end else if (pipe_vld_r[READ_LATENCY-1]) begin
      rsp_valid_r <= ONE_HOT_0 << pipe_id_r[READ_LATENCY-1];
      rsp_data_r  <= bram_dout_in;
    end else begin
      rsp_valid_r <= '0;
      rsp_data_r  <= rsp_data_r;
    end
  end

  assign rsp_valid_out = rsp_valid_r;
  assign rsp_data_out  = rsp_data_r;

endmodule
